uart_loopback_fifo: RTL and testbench
=====================================

# uart_loopback_fifo

Byte buffer and transmit sequencer between `uart_rx` and `uart_tx` in the loopback path of `uart_top`. It captures each received byte into a circular FIFO and replays the stored bytes to `uart_tx` one at a time through a start/busy handshake. Back-to-back received bytes are not lost while the transmitter is occupied.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; must be a power of two, minimum 2.
- `PTR_W`, `$clog2(DEPTH)`: pointer width. Derived; do not override.

Ports:
- `clk` input 1: system clock, 50 MHz.
- `reset` input 1: asynchronous, active-high reset.
- `rx_data` input 8: received byte from `uart_rx.data_out`.
- `rx_valid` input 1: `uart_rx.data_ready`; may be held for one or more cycles.
- `tx_busy` input 1: `uart_tx.busy`.
- `tx_start` output 1: request to `uart_tx.start`.
- `tx_data` output 8: byte to `uart_tx.data_in`.
- `count` output PTR_W+1: current occupancy, 0..DEPTH.
- `full` output 1: `count == DEPTH`.
- `empty` output 1: `count == 0`.
- `overflow` output 1: sticky flag; set when a byte is dropped.

## Operation
- **Push**
  - Push happens on the rising edge of `rx_valid`: `rx_valid` is 1 and its registered copy is 0.
  - Holding `rx_valid` high for several cycles produces exactly one push.
- **Pop**
  - Pop happens in the cycle the FSM moves from IDLE to LAUNCH.
  - The head byte is registered into `tx_data` at that point.
- **Overflow**
  - A push while `full` with no pop in the same cycle drops the byte.
  - The FIFO contents are unchanged, and `overflow` is set to 1 until reset.
- **Simultaneous push and pop**
  - Both are performed. `count` is unchanged.
  - This is legal even when `full` is 1.
  - When `empty` is 1, no pop can occur, so a push to an empty FIFO is only a push.
- **Pointers**
  - Read and write pointers are PTR_W bits wide and wrap modulo DEPTH.
  - `count` is a separate PTR_W+1 bit register.
- **Transmit FSM**
  - IDLE: when `empty` is 0, pop and go to LAUNCH.
  - LAUNCH: `tx_start` = 1. Stay until `tx_busy` = 1, then go to WAIT_DONE.
  - WAIT_DONE: `tx_start` = 0. When `tx_busy` = 0, go to IDLE, or to CRLF when that feature is compiled in and applies.
  - CRLF (only with the macro): load `tx_data` = 0x0A and go to LAUNCH.
- **`tx_data` stability**: held constant from entry into LAUNCH until the FSM next leaves WAIT_DONE.

## Timing
- **Reset values**: `tx_start` 0, `tx_data` 0x00, `count` 0, `empty` 1, `full` 0, `overflow` 0, FSM in IDLE, pointers 0, `rx_valid` edge register 0.
- **Push latency**: a push detected in cycle N updates `count`, `empty` and `full` at the edge ending cycle N; they are visible in N+1.
- **Start latency**: if the FIFO is non-empty in IDLE in cycle N, `tx_start` = 1 and `tx_data` are valid in N+1.
- **Empty FIFO**: a byte pushed into an empty FIFO in cycle N produces `tx_start` in N+2.
- **Back-to-back bytes**: the next `tx_start` comes no earlier than 2 cycles after `tx_busy` falls. It is never asserted while `tx_busy` is 1 in WAIT_DONE.
- **Reset mid-frame**: all state clears immediately, `tx_start` deasserts asynchronously, and any queued bytes are discarded.

## Configuration
- **Macro**: `UART_LOOPBACK_CRLF_EN`.
- **Defined**:
  - After a transmitted byte equal to 0x0D completes, the FSM goes through CRLF and sends 0x0A.
  - The 0x0A is not stored in the FIFO and does not change `count`.
- **Undefined**: the CRLF state and its logic are absent, and 0x0D is sent like any other byte.

## Structure
- **Package `uart_pkg`**:
  - FSM state enum `tx_seq_state_t`: IDLE, LAUNCH, WAIT_DONE, CRLF.
  - Constants `ASCII_CR` = 8'h0D and `ASCII_LF` = 8'h0A.
- **Sub-module `sync_fifo`**: holds the storage array, pointers, `count`, `full`, `empty` and `overflow`; parameterised by DEPTH and width 8.
- **Top level of this block**: the `rx_valid` edge detector and the transmit FSM.

## Test plan
- **Single byte**: after reset, pulse `rx_valid` with 0x41; model `tx_busy` high for 20 cycles after `tx_start`. Expect exactly one `tx_start` with `tx_data` = 0x41, then `empty` = 1.
- **Held valid**: hold `rx_valid` high for 5 cycles with 0x55. Expect `count` to peak at 1 and exactly one 0x55 transmitted.
- **Burst ordering**: push 0x01..0x10 (16 bytes) while `tx_busy` is held high. Expect `full` = 1 and `overflow` = 0, then transmission in order 0x01..0x10.
- **Overflow**: with the FIFO full, push 0x99. Expect `overflow` = 1, `count` = 16 and 0x99 never transmitted. Simultaneous push and pop with a full FIFO keeps `count` = 16 and sets no overflow.
- **CRLF**: push 0x0D then 0x42. With the macro, expect the sequence 0x0D, 0x0A, 0x42. Without it, expect 0x0D, 0x42.
- **Reset mid-frame**: assert `reset` during LAUNCH with 3 bytes queued. Expect `tx_start` = 0 immediately, `count` = 0 and no further starts.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART loopback path: transmit sequencer states and ASCII codes.
// No logic; imported by the loopback buffer and its FIFO.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE,
        CRLF
    } tx_seq_state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/sync_fifo.sv
// Circular byte FIFO with occupancy count and sticky overflow; push/pop take effect at the clock edge.
// A push while full is accepted only when a pop frees a slot in the same cycle, otherwise it is dropped.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && !do_push) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_loopback_fifo.sv
// Loopback buffer: rx_valid rising edge pushes a byte; FSM pops and replays bytes to uart_tx via start/busy, tx_start 2 cycles after a push into an empty FIFO.
// Bytes arriving while full are dropped (sticky overflow). UART_LOOPBACK_CRLF_EN appends 0x0A after each transmitted 0x0D.
module uart_loopback_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [7:0]     rx_data,
    input  logic           rx_valid,
    input  logic           tx_busy,
    output logic           tx_start,
    output logic [7:0]     tx_data,
    output logic [PTR_W:0] count,
    output logic           full,
    output logic           empty,
    output logic           overflow
);

    tx_seq_state_t state;
    tx_seq_state_t next_state;
    logic          rx_valid_q;
    logic          push;
    logic          pop;
    logic [7:0]    head;

    assign push = rx_valid && !rx_valid_q;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .wr_data  (rx_data),
        .pop      (pop),
        .rd_data  (head),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_valid_q <= 1'b0;
            state      <= IDLE;
            tx_data    <= 8'h00;
        end else begin
            rx_valid_q <= rx_valid;
            state      <= next_state;
            if (pop) begin
                tx_data <= head;
`ifdef UART_LOOPBACK_CRLF_EN
            end else if (state == CRLF) begin
                tx_data <= ASCII_LF;
`endif
            end
        end
    end

    // tx_start decodes straight from state so reset drops it without waiting for a clock.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        tx_start   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    next_state = LAUNCH;
                end
            end
            LAUNCH: begin
                tx_start = 1'b1;
                if (tx_busy) begin
                    next_state = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
`ifdef UART_LOOPBACK_CRLF_EN
                    next_state = (tx_data == ASCII_CR) ? CRLF : IDLE;
`else
                    next_state = IDLE;
`endif
                end
            end
`ifdef UART_LOOPBACK_CRLF_EN
            CRLF: begin
                next_state = LAUNCH;
            end
`endif
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_loopback_fifo.sv
// Scoreboard bench for uart_loopback_fifo: stimulus queues expected transmitted bytes, a monitor checks each tx_start.
// Honours UART_LOOPBACK_CRLF_EN when building the expected byte stream.
module tb_uart_loopback_fifo;
    import uart_pkg::*;

    localparam int DEPTH = 16;
    localparam int PTR_W = $clog2(DEPTH);

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [7:0]     rx_data = 8'h00;
    logic           rx_valid = 1'b0;
    logic           busy_model = 1'b0;
    logic           busy_force = 1'b0;
    logic           tx_busy;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic [PTR_W:0] count;
    logic           full;
    logic           empty;
    logic           overflow;

    int         tests = 0;
    int         fails = 0;
    int         n_starts = 0;
    bit         model_en = 1'b0;
    int         busy_min = 3;
    int         busy_max = 8;
    logic [7:0] exp_q[$];

    assign tx_busy = busy_model | busy_force;

    always #10 clk = ~clk;

    uart_loopback_fifo #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_busy  (tx_busy),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference behaviour: every accepted byte is sent once, in order; a CR gains a trailing LF when enabled.
    function automatic void expect_byte(input logic [7:0] b);
        exp_q.push_back(b);
`ifdef UART_LOOPBACK_CRLF_EN
        if (b == ASCII_CR) begin
            exp_q.push_back(ASCII_LF);
        end
`endif
    endfunction

    task automatic push_byte(input logic [7:0] b, input int hold);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        repeat (hold) @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && empty && !tx_start && !tx_busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL %s: drain timed out with %0d bytes outstanding, expected 0", name, exp_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    // Monitor: each new tx_start must carry the oldest expected byte.
    initial begin
        bit prev = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start && !prev) begin
                n_starts++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_start: tx_data 0x%0h, expected no transmission", tx_data);
                end else begin
                    check("tx_order", tx_data, exp_q.pop_front());
                end
            end
            prev = tx_start;
        end
    end

    // Transmitter model: answers a start with a busy pulse of bounded random length.
    initial begin
        forever begin
            @(negedge clk);
            if (model_en && tx_start && !busy_model) begin
                repeat ($urandom_range(1, 2)) @(negedge clk);
                busy_model = 1'b1;
                repeat ($urandom_range(busy_min, busy_max)) @(negedge clk);
                busy_model = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int peak;
        logic [7:0] b;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_tx_start", tx_start, 0);
        check("reset_tx_data", tx_data, 8'h00);
        check("reset_count", count, 0);
        check("reset_empty", empty, 1);
        check("reset_full", full, 0);
        check("reset_overflow", overflow, 0);

        // Single byte with a 20-cycle transmitter.
        model_en = 1'b1;
        busy_min = 20;
        busy_max = 20;
        s0 = n_starts;
        expect_byte(8'h41);
        @(negedge clk);
        rx_data  = 8'h41;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        check("single_count_n1", count, 1);
        check("single_start_n1", tx_start, 0);
        @(negedge clk);
        check("single_start_n2", tx_start, 1);
        check("single_data_n2", tx_data, 8'h41);
        check("single_count_n2", count, 0);
        wait_drain("single_drain");
        check("single_empty", empty, 1);
        check("single_starts", n_starts - s0, 1);

        // Held valid yields one push.
        busy_min = 3;
        busy_max = 8;
        s0 = n_starts;
        peak = 0;
        expect_byte(8'h55);
        @(negedge clk);
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (int'(count) > peak) peak = int'(count);
        end
        rx_valid = 1'b0;
        check("held_peak", peak, 1);
        wait_drain("held_drain");
        check("held_starts", n_starts - s0, 1);

        // Burst with transmitter stalled in WAIT_DONE, then push+pop while full, then overflow.
        model_en   = 1'b0;
        busy_force = 1'b1;
        expect_byte(8'hEE);
        push_byte(8'hEE, 1);
        repeat (4) @(negedge clk);
        for (int i = 1; i <= 16; i++) begin
            expect_byte(8'(i));
            push_byte(8'(i), 1);
        end
        @(negedge clk);
        check("burst_count", count, 16);
        check("burst_full", full, 1);
        check("burst_overflow", overflow, 0);

        @(negedge clk);
        busy_force = 1'b0;
        @(negedge clk);
        busy_force = 1'b1;
        rx_data    = 8'h77;
        rx_valid   = 1'b1;
        expect_byte(8'h77);
        @(negedge clk);
        rx_valid = 1'b0;
        check("pushpop_count", count, 16);
        check("pushpop_full", full, 1);
        check("pushpop_overflow", overflow, 0);

        push_byte(8'h99, 1);
        @(negedge clk);
        check("ovf_flag", overflow, 1);
        check("ovf_count", count, 16);

        model_en   = 1'b1;
        busy_force = 1'b0;
        wait_drain("burst_drain");
        check("ovf_sticky", overflow, 1);

        // CR followed by an ordinary byte.
        expect_byte(ASCII_CR);
        push_byte(ASCII_CR, 1);
        expect_byte(8'h42);
        push_byte(8'h42, 1);
        wait_drain("crlf_drain");

        // Randomised traffic, never pushing into a full FIFO.
        busy_min = 2;
        busy_max = 10;
        for (int i = 0; i < 40; i++) begin
            for (int w = 0; w < 2000 && full; w++) @(negedge clk);
            b = 8'($urandom);
            expect_byte(b);
            push_byte(b, $urandom_range(1, 3));
            repeat ($urandom_range(0, 12)) @(negedge clk);
        end
        wait_drain("random_drain");
        check("random_count", count, 0);

        // Reset during LAUNCH with three bytes queued.
        model_en = 1'b0;
        s0 = n_starts;
        expect_byte(8'hA1);
        push_byte(8'hA1, 1);
        push_byte(8'hB2, 1);
        push_byte(8'hC3, 1);
        push_byte(8'hD4, 1);
        @(negedge clk);
        check("midrst_launch", tx_start, 1);
        check("midrst_queued", count, 3);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_start_async", tx_start, 0);
        check("midrst_count", count, 0);
        check("midrst_empty", empty, 1);
        @(negedge clk);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        check("midrst_starts", n_starts - s0, 1);
        check("midrst_outstanding", exp_q.size(), 0);
        check("midrst_tx_data", tx_data, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
